// File: rtl/ir_fetch_unit.sv
// Instruction fetch stage: issues one memory read per fetch request, waits out
// variable latency, latches IR, and traps misaligned PCs / timeouts with a NOP.
module ir_fetch_unit #(
  parameter int               ADDR_W  = 32,
  parameter int               DATA_W  = 32,
  parameter int               TIMEOUT = 15,
  parameter logic [DATA_W-1:0] NOP_IR = 32'hE1A00000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] IR,
  output logic              W_IR_valid,
  output logic              fetch_err,
  output logic              busy,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_ir, w_ir_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_rd, w_rd_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_err, w_err_nxt;
  logic                r_busy;
  logic [31:0]         r_cnt, w_cnt_nxt;
  logic [7:0]          r_wait, w_wait_nxt;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_ir_nxt    = r_ir;
    w_addr_nxt  = r_addr;
    w_rd_nxt    = r_rd;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_wait_nxt  = r_wait;
    case (r_state)
      S_IDLE: begin
        if (fetch_req) begin
          if (pc_addr[1:0] == 2'b00) begin
            w_addr_nxt  = pc_addr;
            w_rd_nxt    = 1'b1;
            w_wait_nxt  = 8'd0;
            w_state_nxt = S_REQ;
          end else begin
            w_ir_nxt    = NOP_IR;
            w_valid_nxt = 1'b1;
            w_err_nxt   = 1'b1;
            w_cnt_nxt   = r_cnt + 32'd1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_REQ: begin
        // A ready arriving on the timeout cycle still counts as a good fetch.
        if (mem_ready && r_rd) begin
          w_ir_nxt    = mem_rdata;
          w_valid_nxt = 1'b1;
          w_rd_nxt    = 1'b0;
          w_cnt_nxt   = r_cnt + 32'd1;
          w_state_nxt = S_DONE;
        end else if (r_wait == WAIT_LAST) begin
          w_ir_nxt    = NOP_IR;
          w_valid_nxt = 1'b1;
          w_err_nxt   = 1'b1;
          w_rd_nxt    = 1'b0;
          w_cnt_nxt   = r_cnt + 32'd1;
          w_state_nxt = S_DONE;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      S_DONE: begin
        if (!fetch_req) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ir    <= NOP_IR;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ir    <= w_ir_nxt;
      r_addr  <= w_addr_nxt;
      r_rd    <= w_rd_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_cnt   <= w_cnt_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  assign mem_addr   = r_addr;
  assign mem_rd     = r_rd;
  assign IR         = r_ir;
  assign W_IR_valid = r_valid;
  assign fetch_err  = r_err;
  assign busy       = r_busy;
  assign fetch_cnt  = r_cnt;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Bench for ir_fetch_unit: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ir_fetch_unit;

  localparam int          TIMEOUT = 15;
  localparam logic [31:0] NOP     = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] pc_addr = '0;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] IR;
  logic        W_IR_valid;
  logic        fetch_err;
  logic        busy;
  logic [31:0] fetch_cnt;

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0;
  int n_rd = 0;

  ir_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .NOP_IR(NOP)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_addr(pc_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .IR(IR), .W_IR_valid(W_IR_valid),
    .fetch_err(fetch_err), .busy(busy), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch is either outstanding (read pending), parked
  // (completed, waiting for the request to drop), or neither.
  logic        model_live = 1'b0;
  logic [31:0] m_ir, m_addr, m_cnt;
  logic        m_rd, m_valid, m_err, m_hold;
  int          m_waits;

  task automatic complete(input logic [31:0] word, input logic err);
    m_ir    <= word;
    m_valid <= 1'b1;
    m_err   <= err;
    m_cnt   <= m_cnt + 1;
    m_rd    <= 1'b0;
    m_hold  <= 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_live <= 1'b1;
      m_ir <= NOP; m_addr <= '0; m_cnt <= '0;
      m_rd <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0; m_hold <= 1'b0;
      m_waits <= 0;
    end else begin
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      if (m_rd) begin
        if (mem_ready) complete(mem_rdata, 1'b0);
        else if (m_waits + 1 == TIMEOUT) complete(NOP, 1'b1);
        else m_waits <= m_waits + 1;
      end else if (m_hold) begin
        if (!fetch_req) m_hold <= 1'b0;
      end else if (fetch_req) begin
        if (pc_addr % 4 != 0) complete(NOP, 1'b1);
        else begin
          m_addr  <= pc_addr;
          m_rd    <= 1'b1;
          m_waits <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("ir", IR, m_ir);
      check("mem_addr", mem_addr, m_addr);
      check("mem_rd", {31'd0, mem_rd}, {31'd0, m_rd});
      check("w_ir_valid", {31'd0, W_IR_valid}, {31'd0, m_valid});
      check("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
      check("busy", {31'd0, busy}, {31'd0, m_rd | m_hold});
      check("fetch_cnt", fetch_cnt, m_cnt);
      n_valid += int'(W_IR_valid);
      n_rd    += int'(mem_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_rd    = 0;
  endtask

  initial begin
    // 1: reset state, then zero-wait fetch
    rst = 1'b1;
    tick(); tick();
    check("rst_ir", IR, NOP);
    check("rst_strobes", {29'd0, mem_rd, W_IR_valid, fetch_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);
    rst = 1'b0;
    tick();
    clear_counts();
    pc_addr = 32'h100; fetch_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hEA000004;
    tick();
    check("t1_rd", {31'd0, mem_rd}, 32'd1);
    check("t1_addr", mem_addr, 32'h100);
    tick();
    check("t1_valid", {31'd0, W_IR_valid}, 32'd1);
    check("t1_ir", IR, 32'hEA000004);
    check("t1_cnt", fetch_cnt, 32'd1);
    fetch_req = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    check("t1_n_valid", n_valid, 1);
    check("t1_n_rd", n_rd, 1);

    // 2: five stall cycles, PC changes mid-wait
    clear_counts();
    pc_addr = 32'h104; fetch_req = 1'b1; mem_rdata = 32'hE0810002;
    tick();
    check("t2_addr_a", mem_addr, 32'h104);
    tick(); tick();
    pc_addr = 32'h108;
    tick(); tick(); tick();
    check("t2_addr_b", mem_addr, 32'h104);
    check("t2_rd_held", {31'd0, mem_rd}, 32'd1);
    mem_ready = 1'b1;
    tick();
    check("t2_ir", IR, 32'hE0810002);
    check("t2_err", {31'd0, fetch_err}, 32'd0);
    check("t2_cnt", fetch_cnt, 32'd2);
    fetch_req = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    check("t2_n_rd", n_rd, 6);
    check("t2_n_valid", n_valid, 1);

    // 3: timeout
    clear_counts();
    pc_addr = 32'h110; fetch_req = 1'b1;
    tick();
    repeat (TIMEOUT - 1) tick();
    check("t3_rd_last", {31'd0, mem_rd}, 32'd1);
    tick();
    check("t3_rd_drop", {31'd0, mem_rd}, 32'd0);
    check("t3_pulse", {30'd0, W_IR_valid, fetch_err}, 32'd3);
    check("t3_ir", IR, NOP);
    check("t3_cnt", fetch_cnt, 32'd3);
    fetch_req = 1'b0;
    tick(); tick();
    check("t3_n_rd", n_rd, 15);
    check("t3_n_valid", n_valid, 1);

    // 4: misaligned PC
    clear_counts();
    pc_addr = 32'h102; fetch_req = 1'b1;
    tick();
    check("t4_pulse", {30'd0, W_IR_valid, fetch_err}, 32'd3);
    check("t4_ir", IR, NOP);
    check("t4_cnt", fetch_cnt, 32'd4);
    fetch_req = 1'b0;
    tick(); tick();
    check("t4_n_rd", n_rd, 0);
    check("t4_n_valid", n_valid, 1);

    // 5: held request yields one fetch; re-arm gives a second
    clear_counts();
    pc_addr = 32'h108; fetch_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h11111111;
    repeat (20) tick();
    check("t5_n_valid_held", n_valid, 1);
    check("t5_n_rd_held", n_rd, 1);
    check("t5_ir", IR, 32'h11111111);
    check("t5_busy", {31'd0, busy}, 32'd1);
    fetch_req = 1'b0; mem_ready = 1'b0;
    tick();
    pc_addr = 32'h10C; fetch_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h22222222;
    tick();
    check("t5_addr2", mem_addr, 32'h10C);
    tick();
    check("t5_ir2", IR, 32'h22222222);
    check("t5_cnt", fetch_cnt, 32'd6);
    fetch_req = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    check("t5_n_valid", n_valid, 2);

    // 6: reset during third wait cycle; late ready ignored
    clear_counts();
    pc_addr = 32'h120; fetch_req = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("t6_rd", {31'd0, mem_rd}, 32'd0);
    check("t6_ir", IR, NOP);
    check("t6_cnt", fetch_cnt, 32'd0);
    rst = 1'b0; fetch_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick(); tick(); tick();
    check("t6_n_valid", n_valid, 0);
    check("t6_ir_hold", IR, NOP);
    mem_ready = 1'b0;

    // 7: ready coincides with the timeout cycle -> normal completion
    clear_counts();
    pc_addr = 32'h130; fetch_req = 1'b1;
    tick();
    repeat (TIMEOUT - 1) tick();
    mem_ready = 1'b1; mem_rdata = 32'h33333333;
    tick();
    check("t7_ir", IR, 32'h33333333);
    check("t7_pulse", {30'd0, W_IR_valid, fetch_err}, 32'd2);
    check("t7_cnt", fetch_cnt, 32'd1);
    fetch_req = 1'b0; mem_ready = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
